ahb_delay_inject: RTL and testbench
===================================

AHB_DELAY_INJECT -- requirements
Module: ahb_delay_inject

Interface
REQ-001 Parameter NUM_RGN, default 2: number of address windows that can be delayed (1..8).
REQ-002 Parameter CNT_W, default 16: width of each per-window delay count.
REQ-003 Parameter DLY_WR, default 0: when 1, write transfers are delayed as well as reads.
REQ-004 Parameter PROT_CHK, default 1: when 1, a window hit also requires hprot[3]=1.
REQ-005 cpu_clk  in  1  single clock for the whole block.
REQ-006 cpu_rst  in  1  reset, synchronous and active-high.
REQ-007 biu_pad_haddr/hburst/hprot/hsize/htrans/hwrite  in  32/3/4/3/2/1  upstream address phase.
REQ-008 pad_biu_hready  in  1  downstream ready.
REQ-009 delay_en  in  1  global enable; 0 = full bypass.
REQ-010 rgn_base, rgn_mask  in  NUM_RGN*32 each  window i hits when (haddr & mask_i) == base_i.
REQ-011 rgn_dly  in  NUM_RGN*CNT_W  delay in cycles for window i.
REQ-012 fifo_pad_haddr/hburst/hprot/hsize/htrans/hwrite  out  32/3/4/3/2/1  downstream address phase.
REQ-013 fifo_biu_hready  out  1  upstream ready.
REQ-014 dly_busy  out  1  high whenever the state is not IDLE.
REQ-015 dly_total  out  16  count of delayed transfers; saturates at 16'hFFFF.

Function
REQ-016 Capture condition: state IDLE, delay_en=1, htrans=NONSEQ, pad_biu_hready=1, (hwrite=0 or DLY_WR=1), PROT_CHK rule met, window hit with rgn_dly!=0.
REQ-017 Window priority: the lowest-index hitting window wins; a zero delay means no capture.
REQ-018 In the capture cycle, fifo_pad_htrans SHALL be IDLE (2'b00) and fifo_biu_hready SHALL equal pad_biu_hready.
REQ-019 On capture, the block latches the full address phase, loads counter = rgn_dly of the winning window, and enters HOLD.
REQ-020 Configuration inputs are sampled only at capture; later changes do not affect an in-flight delay.
REQ-021 HOLD: fifo_biu_hready=0, fifo_pad_htrans=IDLE, and the counter decrements each cycle; the block enters ISSUE when the counter is 1.
REQ-022 ISSUE: the latched phase is driven on fifo_pad_* with fifo_biu_hready=0; the block holds ISSUE until pad_biu_hready=1, then goes to PASS.
REQ-023 A delay of D therefore holds the latched phase off the pad for exactly D cycles after capture.
REQ-024 PASS: all outputs bypass the upstream inputs and fifo_biu_hready=pad_biu_hready.
REQ-025 PASS exit, beats: remaining beats are loaded from the latched hburst (SINGLE 0, 4-beat 3, 8-beat 7, 16-beat 15).
REQ-026 PASS exit, counting: the beat count decrements on each accepted SEQ; the block returns to IDLE when the count is 0.
REQ-027 PASS exit, INCR: for INCR, or on any accepted IDLE/NONSEQ, the block returns to IDLE and the capture rule applies to that NONSEQ in the same cycle.
REQ-028 SEQ and BUSY beats are never captured; while in PASS no capture occurs.
REQ-029 Outside HOLD and ISSUE, fifo_pad_* are combinationally equal to biu_pad_*, except in the capture cycle per REQ-018.
REQ-030 dly_total increments by 1 on each capture.

Reset
REQ-031 While cpu_rst=1 at a cpu_clk edge: state IDLE, counter 0, beat count 0, latched phase 0, dly_total 0.
REQ-032 After reset: fifo_biu_hready = pad_biu_hready, fifo_pad_* = biu_pad_*, dly_busy=0.
REQ-033 A reset asserted in HOLD, ISSUE or PASS discards the latched transfer with no downstream issue.

Structure
REQ-034 Package ahb_dly_pkg SHALL hold the HTRANS/HBURST encodings, the state enumeration (IDLE/HOLD/ISSUE/PASS) and the beat-count lookup function.
REQ-035 Sub-module ahb_dly_counter SHALL implement the loadable CNT_W-bit down-counter with done flag (counter==1).

Verification
REQ-036 Scenario 1: delay_en=0, read 0x2000_0010 -> output equals input every cycle, dly_total=0.
REQ-037 Scenario 2: window0 base 0x2000_0000 mask 0xFFFE_0000 dly 5, NONSEQ SINGLE read 0x2000_0004, hprot=4'hF -> pad IDLE for 5 cycles, then the latched phase appears, fifo_biu_hready low 6 cycles, dly_total=1.
REQ-038 Scenario 3: WRAP4 read hit dly 3 -> first beat delayed 3 cycles, 3 SEQ beats bypass with zero added latency, then IDLE.
REQ-039 Scenario 4: windows 0 and 1 overlap at 0x6000_0000 (dly 2 and 9) -> 2-cycle delay; write to same address with DLY_WR=0 -> no delay.
REQ-040 Scenario 5: pad_biu_hready held low 4 cycles in ISSUE -> latched phase stable, fifo_biu_hready=0 throughout.
REQ-041 Scenario 6: cpu_rst pulsed during HOLD (counter 3) -> next cycle IDLE, pad sees no latched transfer, dly_total=0.

Source files
------------

// File: rtl/ahb_dly_pkg.sv
// Shared AHB encodings, FSM state type and burst-length lookup for the delay injector.
package ahb_dly_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_PASS  = 2'd3
    } dly_state_e;

    typedef struct packed {
        logic [31:0] haddr;
        logic [2:0]  hburst;
        logic [3:0]  hprot;
        logic [2:0]  hsize;
        logic [1:0]  htrans;
        logic        hwrite;
    } ahb_aphase_t;

    // Beats still to come after the first one; INCR is open-ended and reports 0.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
            HBURST_WRAP16, HBURST_INCR16: return 4'd15;
            default:                      return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_dly_counter.sv
// Loadable down-counter timing the HOLD phase; done flags the last hold cycle.
module ahb_dly_counter
    import ahb_dly_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ahb_delay_inject.sv
// AHB address-phase delay injector: holds NONSEQ transfers hitting a configured window
// for a programmable number of cycles before issuing them downstream.
module ahb_delay_inject
    import ahb_dly_pkg::*;
#(
    parameter int NUM_RGN  = 2,
    parameter int CNT_W    = 16,
    parameter int DLY_WR   = 0,
    parameter int PROT_CHK = 1
) (
    input  logic                     cpu_clk,
    input  logic                     cpu_rst,
    input  logic [31:0]              biu_pad_haddr,
    input  logic [2:0]               biu_pad_hburst,
    input  logic [3:0]               biu_pad_hprot,
    input  logic [2:0]               biu_pad_hsize,
    input  logic [1:0]               biu_pad_htrans,
    input  logic                     biu_pad_hwrite,
    input  logic                     pad_biu_hready,
    input  logic                     delay_en,
    input  logic [NUM_RGN*32-1:0]    rgn_base,
    input  logic [NUM_RGN*32-1:0]    rgn_mask,
    input  logic [NUM_RGN*CNT_W-1:0] rgn_dly,
    output logic [31:0]              fifo_pad_haddr,
    output logic [2:0]               fifo_pad_hburst,
    output logic [3:0]               fifo_pad_hprot,
    output logic [2:0]               fifo_pad_hsize,
    output logic [1:0]               fifo_pad_htrans,
    output logic                     fifo_pad_hwrite,
    output logic                     fifo_biu_hready,
    output logic                     dly_busy,
    output logic [15:0]              dly_total
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    dly_state_e       state_q, state_d;
    logic [3:0]       beats_q, beats_d;
    ahb_aphase_t      up_ph, lat_q, out_ph;
    logic             win_hit;
    logic [CNT_W-1:0] win_dly;
    logic             prot_ok, dir_ok;
    logic             pass_done, open_win, capture;
    logic             cnt_load, cnt_dec, cnt_done;

    assign up_ph = '{haddr:  biu_pad_haddr,  hburst: biu_pad_hburst,
                     hprot:  biu_pad_hprot,  hsize:  biu_pad_hsize,
                     htrans: biu_pad_htrans, hwrite: biu_pad_hwrite};

    // Walk downwards so the lowest-index hit is the one left standing.
    always_comb begin
        win_hit = 1'b0;
        win_dly = '0;
        for (int i = NUM_RGN - 1; i >= 0; i--) begin
            if ((biu_pad_haddr & rgn_mask[i*32 +: 32]) == rgn_base[i*32 +: 32]) begin
                win_hit = 1'b1;
                win_dly = rgn_dly[i*CNT_W +: CNT_W];
            end
        end
    end

    assign prot_ok = (PROT_CHK == 0) || biu_pad_hprot[3];
    assign dir_ok  = !biu_pad_hwrite || (DLY_WR != 0);

    // A PASS cycle that ends the burst behaves as IDLE, so a fresh NONSEQ can be captured at once.
    assign pass_done = (state_q == ST_PASS) &&
                       ((beats_q == 4'd0) || (lat_q.hburst == HBURST_INCR) ||
                        (pad_biu_hready && ((biu_pad_htrans == HTRANS_IDLE) ||
                                            (biu_pad_htrans == HTRANS_NONSEQ))));
    assign open_win  = (state_q == ST_IDLE) || pass_done;
    assign capture   = open_win && delay_en && (biu_pad_htrans == HTRANS_NONSEQ) &&
                       pad_biu_hready && dir_ok && prot_ok && win_hit && (win_dly != '0);

    always_comb begin
        state_d         = state_q;
        beats_d         = beats_q;
        cnt_load        = 1'b0;
        cnt_dec         = 1'b0;
        out_ph          = up_ph;
        fifo_biu_hready = pad_biu_hready;
        case (state_q)
            ST_HOLD: begin
                out_ph.htrans   = HTRANS_IDLE;
                fifo_biu_hready = 1'b0;
                cnt_dec         = 1'b1;
                if (cnt_done) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                out_ph          = lat_q;
                fifo_biu_hready = 1'b0;
                if (pad_biu_hready) begin
                    state_d = ST_PASS;
                    beats_d = burst_beats(lat_q.hburst);
                end
            end
            ST_PASS: begin
                if (pass_done) begin
                    state_d = ST_IDLE;
                    beats_d = '0;
                end else if (pad_biu_hready && (biu_pad_htrans == HTRANS_SEQ)) begin
                    beats_d = beats_q - 4'd1;
                    if (beats_q == 4'd1) state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
        if (capture) begin
            state_d       = ST_HOLD;
            cnt_load      = 1'b1;
            out_ph.htrans = HTRANS_IDLE;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q   <= ST_IDLE;
            beats_q   <= '0;
            lat_q     <= '0;
            dly_total <= '0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            if (capture) begin
                lat_q     <= up_ph;
                dly_total <= sat_inc(dly_total);
            end
        end
    end

    ahb_dly_counter #(.CNT_W(CNT_W)) u_cnt (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (win_dly),
        .done     (cnt_done)
    );

    assign fifo_pad_haddr  = out_ph.haddr;
    assign fifo_pad_hburst = out_ph.hburst;
    assign fifo_pad_hprot  = out_ph.hprot;
    assign fifo_pad_hsize  = out_ph.hsize;
    assign fifo_pad_htrans = out_ph.htrans;
    assign fifo_pad_hwrite = out_ph.hwrite;
    assign dly_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ahb_delay_inject.sv
// Directed bench for ahb_delay_inject: per-cycle expected outputs plus an ordered queue of downstream NONSEQ issues.
module tb_ahb_delay_inject;
    import ahb_dly_pkg::*;

    localparam int NUM_RGN = 2;
    localparam int CNT_W   = 16;

    logic                     cpu_clk = 1'b0;
    logic                     cpu_rst = 1'b1;
    logic [31:0]              biu_pad_haddr = '0;
    logic [2:0]               biu_pad_hburst = '0;
    logic [3:0]               biu_pad_hprot = 4'hF;
    logic [2:0]               biu_pad_hsize = 3'b010;
    logic [1:0]               biu_pad_htrans = '0;
    logic                     biu_pad_hwrite = 1'b0;
    logic                     pad_biu_hready = 1'b1;
    logic                     delay_en = 1'b0;
    logic [NUM_RGN*32-1:0]    rgn_base = '0;
    logic [NUM_RGN*32-1:0]    rgn_mask = '0;
    logic [NUM_RGN*CNT_W-1:0] rgn_dly = '0;
    logic [31:0]              fifo_pad_haddr;
    logic [2:0]               fifo_pad_hburst;
    logic [3:0]               fifo_pad_hprot;
    logic [2:0]               fifo_pad_hsize;
    logic [1:0]               fifo_pad_htrans;
    logic                     fifo_pad_hwrite;
    logic                     fifo_biu_hready;
    logic                     dly_busy;
    logic [15:0]              dly_total;

    typedef struct {
        logic [1:0]  tr;
        logic [31:0] a;
        logic [2:0]  hb;
        logic        rdy;
        logic        busy;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] iss_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;

    always #5 cpu_clk = ~cpu_clk;

    ahb_delay_inject #(.NUM_RGN(NUM_RGN), .CNT_W(CNT_W), .DLY_WR(0), .PROT_CHK(1)) dut (
        .cpu_clk         (cpu_clk),
        .cpu_rst         (cpu_rst),
        .biu_pad_haddr   (biu_pad_haddr),
        .biu_pad_hburst  (biu_pad_hburst),
        .biu_pad_hprot   (biu_pad_hprot),
        .biu_pad_hsize   (biu_pad_hsize),
        .biu_pad_htrans  (biu_pad_htrans),
        .biu_pad_hwrite  (biu_pad_hwrite),
        .pad_biu_hready  (pad_biu_hready),
        .delay_en        (delay_en),
        .rgn_base        (rgn_base),
        .rgn_mask        (rgn_mask),
        .rgn_dly         (rgn_dly),
        .fifo_pad_haddr  (fifo_pad_haddr),
        .fifo_pad_hburst (fifo_pad_hburst),
        .fifo_pad_hprot  (fifo_pad_hprot),
        .fifo_pad_hsize  (fifo_pad_hsize),
        .fifo_pad_htrans (fifo_pad_htrans),
        .fifo_pad_hwrite (fifo_pad_hwrite),
        .fifo_biu_hready (fifo_biu_hready),
        .dly_busy        (dly_busy),
        .dly_total       (dly_total)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_rgn(input int i, input logic [31:0] base, input logic [31:0] mask,
                           input logic [CNT_W-1:0] dly);
        rgn_base[i*32 +: 32]   = base;
        rgn_mask[i*32 +: 32]   = mask;
        rgn_dly[i*CNT_W +: CNT_W] = dly;
    endtask

    task automatic exp_issue(input logic [31:0] a);
        iss_q.push_back(a);
    endtask

    // Drive one cycle of upstream stimulus, queue the expected outputs, check them at the falling edge.
    task automatic step(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] hb,
                        input logic wr, input logic rdy,
                        input logic [1:0] e_tr, input logic [31:0] e_a, input logic [2:0] e_hb,
                        input logic e_rdy, input logic e_busy);
        exp_t e;
        biu_pad_htrans = tr;
        biu_pad_haddr  = a;
        biu_pad_hburst = hb;
        biu_pad_hwrite = wr;
        pad_biu_hready = rdy;
        exp_q.push_back('{e_tr, e_a, e_hb, e_rdy, e_busy});
        @(negedge cpu_clk);
        e = exp_q.pop_front();
        chk("htrans", 32'(fifo_pad_htrans), 32'(e.tr));
        chk("hready", 32'(fifo_biu_hready), 32'(e.rdy));
        chk("busy", 32'(dly_busy), 32'(e.busy));
        if (e.tr != HTRANS_IDLE) begin
            chk("haddr", fifo_pad_haddr, e.a);
            chk("hburst", 32'(fifo_pad_hburst), 32'(e.hb));
        end
        if ((fifo_pad_htrans == HTRANS_NONSEQ) && pad_biu_hready) begin
            chk("issue_expected", 32'(iss_q.size() != 0), 32'd1);
            if (iss_q.size() != 0) chk("issue_addr", fifo_pad_haddr, iss_q.pop_front());
        end
        cyc++;
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge cpu_clk);
        #1;
        // Reset state
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 0);
        chk("total_reset", 32'(dly_total), 32'd0);
        cpu_rst = 1'b0;
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 0, HTRANS_IDLE, 0, 0, 0, 0);

        // Scenario 1: global bypass
        set_rgn(0, 32'h2000_0000, 32'hFFFE_0000, 16'd5);
        set_rgn(1, 32'hF000_0000, 32'hF000_0000, 16'd0);
        exp_issue(32'h2000_0010);
        step(HTRANS_NONSEQ, 32'h2000_0010, HBURST_SINGLE, 0, 1, HTRANS_NONSEQ, 32'h2000_0010, HBURST_SINGLE, 1, 0);
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 0);
        chk("total_s1", 32'(dly_total), 32'd0);

        // Scenario 2: single read delayed 5
        delay_en = 1'b1;
        exp_issue(32'h2000_0004);
        step(HTRANS_NONSEQ, 32'h2000_0004, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 0);
        repeat (5) step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 0, 1);
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_NONSEQ, 32'h2000_0004, HBURST_SINGLE, 0, 1);
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 1);
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 0);
        chk("total_s2", 32'(dly_total), 32'd1);

        // Scenario 3: WRAP4 delayed 3, remaining beats bypass
        set_rgn(0, 32'h2000_0000, 32'hFFFE_0000, 16'd3);
        exp_issue(32'h2000_0100);
        step(HTRANS_NONSEQ, 32'h2000_0100, HBURST_WRAP4, 0, 1, HTRANS_IDLE, 0, 0, 1, 0);
        repeat (3) step(HTRANS_SEQ, 32'h2000_0104, HBURST_WRAP4, 0, 1, HTRANS_IDLE, 0, 0, 0, 1);
        step(HTRANS_SEQ, 32'h2000_0104, HBURST_WRAP4, 0, 1, HTRANS_NONSEQ, 32'h2000_0100, HBURST_WRAP4, 0, 1);
        step(HTRANS_SEQ, 32'h2000_0104, HBURST_WRAP4, 0, 1, HTRANS_SEQ, 32'h2000_0104, HBURST_WRAP4, 1, 1);
        step(HTRANS_SEQ, 32'h2000_0108, HBURST_WRAP4, 0, 1, HTRANS_SEQ, 32'h2000_0108, HBURST_WRAP4, 1, 1);
        step(HTRANS_SEQ, 32'h2000_010C, HBURST_WRAP4, 0, 1, HTRANS_SEQ, 32'h2000_010C, HBURST_WRAP4, 1, 1);
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 0);
        chk("total_s3", 32'(dly_total), 32'd2);

        // Scenario 4: overlapping windows, write bypass, hprot and zero-delay priority
        set_rgn(0, 32'h6000_0000, 32'hFFFF_0000, 16'd2);
        set_rgn(1, 32'h6000_0000, 32'hFF00_0000, 16'd9);
        exp_issue(32'h6000_0020);
        step(HTRANS_NONSEQ, 32'h6000_0020, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 0);
        repeat (2) step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 0, 1);
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_NONSEQ, 32'h6000_0020, HBURST_SINGLE, 0, 1);
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 1);
        exp_issue(32'h6000_0024);
        step(HTRANS_NONSEQ, 32'h6000_0024, HBURST_SINGLE, 1, 1, HTRANS_NONSEQ, 32'h6000_0024, HBURST_SINGLE, 1, 0);
        biu_pad_hprot = 4'h7;
        exp_issue(32'h6000_0028);
        step(HTRANS_NONSEQ, 32'h6000_0028, HBURST_SINGLE, 0, 1, HTRANS_NONSEQ, 32'h6000_0028, HBURST_SINGLE, 1, 0);
        biu_pad_hprot = 4'hF;
        set_rgn(0, 32'h6000_0000, 32'hFFFF_0000, 16'd0);
        exp_issue(32'h6000_002C);
        step(HTRANS_NONSEQ, 32'h6000_002C, HBURST_SINGLE, 0, 1, HTRANS_NONSEQ, 32'h6000_002C, HBURST_SINGLE, 1, 0);
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 0);
        chk("total_s4", 32'(dly_total), 32'd3);

        // Scenario 5: ISSUE stalled by downstream, config change mid-flight, capture on PASS exit
        set_rgn(0, 32'h2000_0000, 32'hFFFE_0000, 16'd2);
        set_rgn(1, 32'hF000_0000, 32'hF000_0000, 16'd0);
        exp_issue(32'h2000_0040);
        step(HTRANS_NONSEQ, 32'h2000_0040, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 0);
        set_rgn(0, 32'h2000_0000, 32'hFFFE_0000, 16'd9);
        repeat (2) step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 0, 1);
        set_rgn(0, 32'h2000_0000, 32'hFFFE_0000, 16'd2);
        repeat (4) step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 0, HTRANS_NONSEQ, 32'h2000_0040, HBURST_SINGLE, 0, 1);
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_NONSEQ, 32'h2000_0040, HBURST_SINGLE, 0, 1);
        exp_issue(32'h2000_0080);
        step(HTRANS_NONSEQ, 32'h2000_0080, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 1);
        repeat (2) step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 0, 1);
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_NONSEQ, 32'h2000_0080, HBURST_SINGLE, 0, 1);
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 1);
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 0);
        chk("total_s5", 32'(dly_total), 32'd5);

        // Scenario 6: reset during HOLD discards the transfer
        set_rgn(0, 32'h2000_0000, 32'hFFFE_0000, 16'd4);
        step(HTRANS_NONSEQ, 32'h2000_0200, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 0);
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 0, 1);
        cpu_rst = 1'b1;
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 0, 1);
        cpu_rst = 1'b0;
        step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 0);
        chk("total_s6", 32'(dly_total), 32'd0);
        repeat (6) step(HTRANS_IDLE, 0, HBURST_SINGLE, 0, 1, HTRANS_IDLE, 0, 0, 1, 0);
        chk("issue_leftover", 32'(iss_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
